// File: rtl/imem_pkg.sv
// Shared constants and state type for the instruction-memory sequencer.
package imem_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;
    localparam logic [6:0] OPC_EXIT = 7'b1111111;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } imem_state_t;

    function automatic logic is_exit(input logic [XLEN-1:0] word);
        return word[6:0] == OPC_EXIT;
    endfunction

endpackage

// File: rtl/imem_bank.sv
// Single-port synchronous instruction RAM, read-first, registered read data.
module imem_bank
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   addr,
    input  logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] rdata
);

    logic [XLEN-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/imem_load_arbiter.sv
// Shares one instruction RAM between the program loader and the IF stage.
// LOAD/RUN/HALT sequencing, pipeline hold during load, stop on exit opcode.
module imem_load_arbiter
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH     = 1024,
    parameter bit          BOOT_LOAD = 1'b1,
    parameter string       INIT_FILE = "",
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ld_valid,
    output logic            ld_ready,
    input  logic [AW-1:0]   ld_addr,
    input  logic [XLEN-1:0] ld_data,
    input  logic            ld_last,
    output logic [AW:0]     ld_count,
    input  logic [31:0]     pc,
    input  logic            stall,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    output logic            core_hold,
    output logic            halted
);

    localparam imem_state_t RESET_STATE = BOOT_LOAD ? LOAD : RUN;
    localparam logic [AW:0] COUNT_MAX = DEPTH[AW:0];

    imem_state_t state_q, state_d;
    logic ready_q;
    logic valid_q, valid_d;
    logic halted_q, halted_d;
    logic settle_q, settle_d;
    logic [AW:0] count_q, count_d;
    logic [AW-1:0] fetch_addr_q, ram_addr;
    logic [XLEN-1:0] rdata;
    logic accept, exit_seen, halting, fetch;
    logic unused_pc;

    assign unused_pc = ^{pc[31:AW+2], pc[1:0]};

    assign accept = (state_q == LOAD) && ready_q && ld_valid;
    // Exit word is already in the output register: behave as HALT from this cycle on.
    assign exit_seen = (state_q == RUN) && valid_q && is_exit(rdata);
    assign halting = (state_q == HALT) || exit_seen;

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        halted_d = halted_q | exit_seen;
        settle_d = settle_q;
        count_d  = count_q;
        fetch    = 1'b0;
        unique case (state_q)
            LOAD: begin
                valid_d = 1'b0;
                if (accept) begin
                    if (count_q != COUNT_MAX) begin
                        count_d = count_q + 1'b1;
                    end
                    if (ld_last) begin
                        state_d  = RUN;
                        halted_d = 1'b0;
                        settle_d = 1'b1;
                    end
                end
            end
            RUN, HALT: begin
                if (ld_valid) begin
                    state_d  = LOAD;
                    valid_d  = 1'b0;
                    count_d  = '0;
                    settle_d = 1'b0;
                end else if (halting) begin
                    state_d = HALT;
                    if (!stall) begin
                        valid_d = 1'b0;
                    end
                end else if (settle_q) begin
                    // One idle cycle after a load before the first fetch.
                    settle_d = 1'b0;
                end else if (!stall) begin
                    fetch   = 1'b1;
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Stalled/halted cycles re-read the last fetch address so rdata holds.
    always_comb begin
        if (state_q == LOAD) begin
            ram_addr = ld_addr;
        end else if (fetch) begin
            ram_addr = pc[AW+1:2];
        end else begin
            ram_addr = fetch_addr_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RESET_STATE;
            ready_q      <= 1'b0;
            valid_q      <= 1'b0;
            halted_q     <= 1'b0;
            settle_q     <= 1'b0;
            count_q      <= '0;
            fetch_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            ready_q  <= (state_d == LOAD);
            valid_q  <= valid_d;
            halted_q <= halted_d;
            settle_q <= settle_d;
            count_q  <= count_d;
            if (fetch) begin
                fetch_addr_q <= pc[AW+1:2];
            end
        end
    end

    imem_bank #(
        .DEPTH    (DEPTH),
        .INIT_FILE(INIT_FILE)
    ) u_bank (
        .clk  (clk),
        .we   (accept),
        .addr (ram_addr),
        .wdata(ld_data),
        .rdata(rdata)
    );

    assign ld_ready    = ready_q;
    assign ld_count    = count_q;
    assign instr       = valid_q ? rdata : NOP_INSTR;
    assign instr_valid = valid_q;
    assign core_hold   = (state_q == LOAD);
    assign halted      = halted_q | exit_seen;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed plus randomized bench for imem_load_arbiter against a behavioural model.
module tb_imem_load_arbiter;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW = 5;
    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADD1 = 32'h002081b3;
    localparam logic [31:0] ADD2 = 32'h00318233;
    localparam logic [31:0] EXIT = 32'h0000007f;
    localparam int M_LOAD = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ld_valid = 1'b0;
    logic ld_last = 1'b0;
    logic stall = 1'b0;
    logic [AW-1:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic [31:0] pc = '0;
    logic ld_ready, instr_valid, core_hold, halted;
    logic [AW:0] ld_count;
    logic [31:0] instr;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_mem [DEPTH];
    int m_mode;
    int m_count;
    bit m_settle, m_ready, m_halted, m_valid;
    logic [31:0] m_instr;

    always #5 clk = ~clk;

    imem_load_arbiter #(
        .DEPTH    (DEPTH),
        .BOOT_LOAD(1'b1),
        .INIT_FILE("")
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_addr    (ld_addr),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_count   (ld_count),
        .pc         (pc),
        .stall      (stall),
        .instr      (instr),
        .instr_valid(instr_valid),
        .core_hold  (core_hold),
        .halted     (halted)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("instr", instr, m_instr);
        check("instr_valid", 32'(instr_valid), 32'(m_valid));
        check("ld_ready", 32'(ld_ready), 32'(m_ready));
        check("core_hold", 32'(core_hold), 32'(m_mode == M_LOAD));
        check("halted", 32'(halted), 32'(m_halted));
        check("ld_count", 32'(ld_count), m_count);
    endtask

    task automatic model_reset();
        m_mode   = M_LOAD;
        m_count  = 0;
        m_settle = 1'b0;
        m_ready  = 1'b0;
        m_halted = 1'b0;
        m_valid  = 1'b0;
        m_instr  = NOP;
    endtask

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_step();
        int idx;
        idx = int'((pc >> 2) % DEPTH);
        if (m_mode == M_LOAD) begin
            m_valid = 1'b0;
            m_instr = NOP;
            if (m_ready && ld_valid) begin
                m_mem[ld_addr] = ld_data;
                if (m_count < DEPTH) m_count++;
                if (ld_last) begin
                    m_mode   = M_RUN;
                    m_halted = 1'b0;
                    m_settle = 1'b1;
                end
            end
        end else if (ld_valid) begin
            m_mode   = M_LOAD;
            m_count  = 0;
            m_valid  = 1'b0;
            m_instr  = NOP;
            m_settle = 1'b0;
        end else if (m_mode == M_HALT) begin
            if (!stall) begin
                m_valid = 1'b0;
                m_instr = NOP;
            end
        end else if (m_settle) begin
            m_settle = 1'b0;
        end else if (!stall) begin
            m_instr = m_mem[idx];
            m_valid = 1'b1;
            if (m_instr[6:0] == 7'h7f) begin
                m_mode   = M_HALT;
                m_halted = 1'b1;
            end
        end
        m_ready = (m_mode == M_LOAD);
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic beat(input logic [AW-1:0] a, input logic [31:0] d, input logic last);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        ld_last  = last;
        for (int i = 0; i < 4 && !m_ready; i++) step();
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    function automatic logic [31:0] rand_word(input bit allow_exit);
        logic [31:0] w;
        w = $urandom;
        if (w[6:0] == 7'h7f) w[0] = 1'b0;
        if (allow_exit && $urandom_range(0, 9) == 0) w[6:0] = 7'h7f;
        return w;
    endfunction

    initial begin
        logic [31:0] w1, w2, wnew;

        // Reset, BOOT_LOAD=1
        #1 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        @(posedge clk);
        #1 reset = 1'b0;

        // Boot load: add, add, exit
        pc = 32'd0;
        beat(5'd0, ADD1, 1'b0);
        beat(5'd1, ADD2, 1'b0);
        beat(5'd2, EXIT, 1'b1);
        check("boot_count", 32'(ld_count), 32'd3);
        check("boot_run_hold", 32'(core_hold), 32'd0);
        step();
        check("boot_bubble", 32'(instr_valid), 32'd0);
        step();
        check("boot_valid", 32'(instr_valid), 32'd1);
        check("boot_w0", instr, ADD1);
        pc = 32'd4;
        step();
        check("boot_w1", instr, ADD2);
        pc = 32'd8;
        step();
        check("boot_exit", instr, EXIT);
        check("boot_halted", 32'(halted), 32'd1);
        pc = 32'd12;
        step();
        check("halt_nop", instr, NOP);
        check("halt_nop_valid", 32'(instr_valid), 32'd0);

        // Reload from HALT, then stall hold
        beat(5'd1, ADD2, 1'b1);
        check("halt_cleared", 32'(halted), 32'd0);
        pc = 32'd0;
        step();
        step();
        pc = 32'd4;
        step();
        check("stall_pre", instr, ADD2);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            pc = 32'(8 + 4 * i);
            step();
            check("stall_hold", instr, ADD2);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end

        // Mid-run reload while stalled
        wnew = 32'h00a00093;
        ld_valid = 1'b1;
        ld_addr  = 5'd0;
        ld_data  = wnew;
        ld_last  = 1'b1;
        step();
        check("reload_hold", 32'(core_hold), 32'd1);
        check("reload_valid", 32'(instr_valid), 32'd0);
        check("reload_ready", 32'(ld_ready), 32'd1);
        step();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        stall    = 1'b0;
        pc       = 32'd0;
        step();
        step();
        check("reload_fetch", instr, wnew);

        // Fill all words with 34 beats; count saturates, addr 1 rewritten last
        w1 = '0;
        for (int i = 0; i < 34; i++) begin
            logic [31:0] w;
            w = rand_word(1'b0);
            if (i % 32 == 1) w1 = w;
            beat(AW'(i), w, i == 33);
        end
        check("sat_count", 32'(ld_count), DEPTH);

        // Wrap and alignment: 0x86 -> word 1
        pc = 32'h86;
        step();
        step();
        check("wrap_fetch", instr, w1);

        // Backpressure: ld_valid 1,0,1 in LOAD
        w1 = rand_word(1'b0);
        w2 = rand_word(1'b0);
        ld_valid = 1'b1;
        ld_addr  = 5'd5;
        ld_data  = w1;
        step();
        check("bp_count_clear", 32'(ld_count), 32'd0);
        step();
        ld_valid = 1'b0;
        ld_addr  = 5'd9;
        ld_data  = 32'hdeadbeef;
        step();
        ld_valid = 1'b1;
        ld_addr  = 5'd6;
        ld_data  = w2;
        step();
        ld_valid = 1'b0;
        check("bp_count", 32'(ld_count), 32'd2);

        // Async reset between beats 2 and 3
        #3 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        check("rst_ready", 32'(ld_ready), 32'd0);
        check("rst_instr", instr, NOP);
        @(posedge clk);
        #1 reset = 1'b0;
        beat(5'd7, ADD1, 1'b1);
        pc = 32'd20;
        step();
        step();
        check("rst_keep1", instr, w1);
        pc = 32'd24;
        step();
        check("rst_keep2", instr, w2);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (m_mode == M_LOAD) begin
                ld_valid = ($urandom_range(0, 3) != 0);
                ld_last  = ($urandom_range(0, 5) == 0);
            end else begin
                ld_valid = ($urandom_range(0, 19) == 0);
                ld_last  = 1'($urandom_range(0, 1));
            end
            ld_addr = AW'($urandom);
            ld_data = rand_word(1'b1);
            pc      = $urandom;
            stall   = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
